blend_scheduler: RTL and testbench
==================================

Name: blend_scheduler

Overview:
- Sequences framebuffer read-modify-write for alpha blending.
- Accepts fragments and issues destination reads to the framebuffer. Feeds the source/destination pair plus blend factors into the fixed-latency colour blender, then writes the blended result back.
- Tracks in-flight pixel addresses so that a later fragment to the same pixel never reads stale destination data.
- Sits between the fragment pipeline and the framebuffer memory port.

Parameters:
- PIXEL_WIDTH, 32, colour word width (4 sub-pixels).
- ADDR_WIDTH, 16, framebuffer pixel address width.
- BLEND_LATENCY, 2, blender input-to-output latency in cycles (≥1).
- MAX_INFLIGHT, 4, in-flight fragment slots; also the depth of the pending FIFO and the output FIFO.

Ports:
- aclk  in  1  clock
- reset  in  1  asynchronous active-high reset
- conf_enable  in  1  blending enabled; 0 = pass source through
- conf_s_factor  in  4  source factor code
- conf_d_factor  in  4  destination factor code
- flush  in  1  level; stop accepting and drain
- flush_done  out  1  one-cycle pulse when drained
- idle  out  1  no fragment in flight
- s_frag_valid / s_frag_ready  in/out  1  fragment handshake
- s_frag_addr  in  ADDR_WIDTH  pixel address
- s_frag_color  in  PIXEL_WIDTH  source colour
- rd_req_valid / rd_req_ready  out/in  1  framebuffer read request
- rd_req_addr  out  ADDR_WIDTH  read address
- rd_rsp_valid / rd_rsp_ready  in/out  1  read response, in order
- rd_rsp_data  in  PIXEL_WIDTH  destination colour
- blend_s_factor, blend_d_factor  out  4  to blender
- blend_src_color, blend_dst_color  out  PIXEL_WIDTH  to blender
- blend_color  in  PIXEL_WIDTH  blender result
- m_wr_valid / m_wr_ready  out/in  1  write-back handshake
- m_wr_addr  out  ADDR_WIDTH  write address
- m_wr_data  out  PIXEL_WIDTH  write data

Behaviour:
- Reset (async, active-high):
  - All valids, FIFOs, the CAM, the delay line and flush_done clear; idle=1; state=RUN.
  - A reset mid-operation discards all in-flight work without emitting writes.
- Address CAM (MAX_INFLIGHT entries, valid+addr):
  - An entry is allocated on fragment accept and freed on the m_wr handshake of that fragment.
  - hazard = any valid entry matching s_frag_addr. This includes an entry being freed in the same cycle (conservative).
- Accept conditions:
  - go = state==RUN & s_frag_valid & !hazard & free CAM slot.
  - rd_req_valid = go & conf_enable. It never depends on rd_req_ready.
  - rd_req_addr = s_frag_addr.
  - s_frag_ready = go & (!conf_enable | rd_req_ready).
- Accepted fragment: {addr, color, bypass=!conf_enable} is pushed into the pending FIFO, registered and visible the next cycle.
- Issue to the blender occurs when the pending head is valid and (bypass | rd_rsp_valid).
  - rd_rsp_ready = head valid & !head.bypass.
  - blend_src_color = head.color.
  - blend_dst_color = rd_rsp_data, or 0 if bypass.
  - Factors are conf_s_factor/conf_d_factor, or ONE/ZERO (shared register-define encodings) if bypass.
  - The head pops on issue.
- Delay line of BLEND_LATENCY stages carries {valid, addr}.
  - When stage BLEND_LATENCY is valid, {addr, blend_color} is pushed into the output FIFO.
  - The blender never stalls. The output FIFO cannot overflow because CAM slots bound total occupancy.
- Output FIFO head drives m_wr_*.
  - Pop on m_wr_valid & m_wr_ready; this frees the matching CAM entry (oldest with that addr).
- Latency: bypass fragment accepted at cycle 0 with empty pipe → issue at cycle 1 → output FIFO push at 1+BLEND_LATENCY → m_wr_valid at 2+BLEND_LATENCY.
- Ordering: writes leave in accept order.
- Counter rule: simultaneous accept and free leave the occupancy count unchanged.
- Flush state machine:
  - RUN → DRAIN when flush=1. In DRAIN, s_frag_ready=0.
  - DRAIN → DONE when the CAM is empty.
  - DONE pulses flush_done for one cycle, then → RUN if flush=0, else it holds in WAIT until flush=0 (no further pulses).
- idle = CAM empty.
- conf_* may change only while idle=1; the result is undefined otherwise.

Test Plan:
- Bypass, BLEND_LATENCY=2: conf_enable=0, frag addr 0x10 color 0x11223344 → no rd_req; m_wr_valid at cycle 4 with addr 0x10, data = blend_color echoing source 0x11223344.
- Blend: conf_enable=1, SRC_ALPHA/ONE_MINUS_SRC_ALPHA, frag 0x20, rd_rsp 0x00000000 after 3 cycles → blend_src/dst/factors presented on issue cycle; one write to 0x20 with blender result.
- Hazard: back-to-back fragments to 0x30 → second s_frag_ready=0 until first m_wr handshake; its rd_req is issued only after the CAM frees.
- Full: MAX_INFLIGHT=4 distinct addresses, m_wr_ready=0 → 5th fragment stalled; one m_wr handshake → 5th accepted next cycle.
- Flush: two fragments in flight, flush=1 → no accepts; flush_done pulses exactly once, one cycle after the last write; idle=1 afterwards.
- Async reset with 3 fragments in flight → all valids 0 immediately, idle=1, no write issued after release.

Source files
------------

// File: rtl/blend_scheduler.sv
// Framebuffer read-modify-write sequencer for alpha blending. A pixel that is
// still in flight stalls new fragments to it until its write-back leaves.
module blend_scheduler #(
  parameter int unsigned PIXEL_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned BLEND_LATENCY = 2,
  parameter int unsigned MAX_INFLIGHT  = 4
) (
  input  logic                   aclk,
  input  logic                   reset,
  input  logic                   conf_enable,
  input  logic [3:0]             conf_s_factor,
  input  logic [3:0]             conf_d_factor,
  input  logic                   flush,
  output logic                   flush_done,
  output logic                   idle,
  input  logic                   s_frag_valid,
  output logic                   s_frag_ready,
  input  logic [ADDR_WIDTH-1:0]  s_frag_addr,
  input  logic [PIXEL_WIDTH-1:0] s_frag_color,
  output logic                   rd_req_valid,
  input  logic                   rd_req_ready,
  output logic [ADDR_WIDTH-1:0]  rd_req_addr,
  input  logic                   rd_rsp_valid,
  output logic                   rd_rsp_ready,
  input  logic [PIXEL_WIDTH-1:0] rd_rsp_data,
  output logic [3:0]             blend_s_factor,
  output logic [3:0]             blend_d_factor,
  output logic [PIXEL_WIDTH-1:0] blend_src_color,
  output logic [PIXEL_WIDTH-1:0] blend_dst_color,
  input  logic [PIXEL_WIDTH-1:0] blend_color,
  output logic                   m_wr_valid,
  input  logic                   m_wr_ready,
  output logic [ADDR_WIDTH-1:0]  m_wr_addr,
  output logic [PIXEL_WIDTH-1:0] m_wr_data
);

  localparam logic [3:0] FACTOR_ZERO = 4'h0;
  localparam logic [3:0] FACTOR_ONE  = 4'h1;
  localparam int unsigned PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_INFLIGHT - 1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE, ST_WAIT} state_e;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  state_e state_q;

  logic [MAX_INFLIGHT-1:0] cam_vld_q, cam_vld_d;
  logic [ADDR_WIDTH-1:0]   cam_addr_q [MAX_INFLIGHT];
  logic [MAX_INFLIGHT-1:0] cam_hit, cam_free_hit;
  logic                    slot_free, hazard, go, accept, wr_fire;
  logic [PTR_W-1:0]        alloc_idx;
  logic [CNT_W-1:0]        occ_q, occ_d;

  logic [ADDR_WIDTH-1:0]   pend_addr_q  [MAX_INFLIGHT];
  logic [PIXEL_WIDTH-1:0]  pend_color_q [MAX_INFLIGHT];
  logic [MAX_INFLIGHT-1:0] pend_byp_q;
  logic [PTR_W-1:0]        pend_wr_q, pend_rd_q;
  logic [CNT_W-1:0]        pend_cnt_q;
  logic                    head_valid, head_byp, issue;

  logic [BLEND_LATENCY-1:0] dly_vld_q;
  logic [ADDR_WIDTH-1:0]    dly_addr_q [BLEND_LATENCY];
  logic                     out_push;

  logic [ADDR_WIDTH-1:0]   out_addr_q [MAX_INFLIGHT];
  logic [PIXEL_WIDTH-1:0]  out_data_q [MAX_INFLIGHT];
  logic [PTR_W-1:0]        out_wr_q, out_rd_q;
  logic [CNT_W-1:0]        out_cnt_q;

  // CAM lookup: hazard on the incoming address, write-back match, lowest free slot
  always_comb begin
    cam_hit      = '0;
    cam_free_hit = '0;
    slot_free    = 1'b0;
    alloc_idx    = '0;
    for (int i = 0; i < int'(MAX_INFLIGHT); i++) begin
      cam_hit[i]      = cam_vld_q[i] && (cam_addr_q[i] == s_frag_addr);
      cam_free_hit[i] = cam_vld_q[i] && (cam_addr_q[i] == m_wr_addr);
      if (!cam_vld_q[i] && !slot_free) begin
        slot_free = 1'b1;
        alloc_idx = PTR_W'(i);
      end
    end
  end

  assign hazard       = |cam_hit;
  assign go           = (state_q == ST_RUN) && s_frag_valid && !hazard && slot_free;
  assign rd_req_valid = go && conf_enable;
  assign rd_req_addr  = s_frag_addr;
  assign s_frag_ready = go && (!conf_enable || rd_req_ready);
  assign accept       = s_frag_ready;
  assign wr_fire      = m_wr_valid && m_wr_ready;

  // One entry per address is guaranteed by the hazard stall, so a free clears at most one slot
  always_comb begin
    cam_vld_d = cam_vld_q & ~(wr_fire ? cam_free_hit : '0);
    if (accept) cam_vld_d[alloc_idx] = 1'b1;
    occ_d = occ_q;
    if (accept && !wr_fire)      occ_d = occ_q + 1'b1;
    else if (!accept && wr_fire) occ_d = occ_q - 1'b1;
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      cam_vld_q <= '0;
      for (int i = 0; i < int'(MAX_INFLIGHT); i++) cam_addr_q[i] <= '0;
    end else begin
      cam_vld_q <= cam_vld_d;
      if (accept) cam_addr_q[alloc_idx] <= s_frag_addr;
    end
  end

  assign head_valid      = (pend_cnt_q != '0);
  assign head_byp        = pend_byp_q[pend_rd_q];
  assign issue           = head_valid && (head_byp || rd_rsp_valid);
  assign rd_rsp_ready    = head_valid && !head_byp;
  assign blend_src_color = pend_color_q[pend_rd_q];
  assign blend_dst_color = head_byp ? '0 : rd_rsp_data;
  assign blend_s_factor  = head_byp ? FACTOR_ONE  : conf_s_factor;
  assign blend_d_factor  = head_byp ? FACTOR_ZERO : conf_d_factor;

  // Pending FIFO: accepted fragments awaiting their destination read
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      pend_wr_q  <= '0;
      pend_rd_q  <= '0;
      pend_cnt_q <= '0;
      pend_byp_q <= '0;
      for (int i = 0; i < int'(MAX_INFLIGHT); i++) begin
        pend_addr_q[i]  <= '0;
        pend_color_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        pend_addr_q[pend_wr_q]  <= s_frag_addr;
        pend_color_q[pend_wr_q] <= s_frag_color;
        pend_byp_q[pend_wr_q]   <= !conf_enable;
        pend_wr_q               <= ptr_inc(pend_wr_q);
      end
      if (issue) pend_rd_q <= ptr_inc(pend_rd_q);
      case ({accept, issue})
        2'b10:   pend_cnt_q <= pend_cnt_q + 1'b1;
        2'b01:   pend_cnt_q <= pend_cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Address shadow of the blender pipeline
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      dly_vld_q <= '0;
      for (int i = 0; i < int'(BLEND_LATENCY); i++) dly_addr_q[i] <= '0;
    end else begin
      dly_vld_q[0]  <= issue;
      dly_addr_q[0] <= pend_addr_q[pend_rd_q];
      for (int i = 1; i < int'(BLEND_LATENCY); i++) begin
        dly_vld_q[i]  <= dly_vld_q[i-1];
        dly_addr_q[i] <= dly_addr_q[i-1];
      end
    end
  end

  assign out_push   = dly_vld_q[BLEND_LATENCY-1];
  assign m_wr_valid = (out_cnt_q != '0);
  assign m_wr_addr  = out_addr_q[out_rd_q];
  assign m_wr_data  = out_data_q[out_rd_q];

  // Output FIFO: occupancy bounded by the CAM, so the blender never needs to stall
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      out_wr_q  <= '0;
      out_rd_q  <= '0;
      out_cnt_q <= '0;
      for (int i = 0; i < int'(MAX_INFLIGHT); i++) begin
        out_addr_q[i] <= '0;
        out_data_q[i] <= '0;
      end
    end else begin
      if (out_push) begin
        out_addr_q[out_wr_q] <= dly_addr_q[BLEND_LATENCY-1];
        out_data_q[out_wr_q] <= blend_color;
        out_wr_q             <= ptr_inc(out_wr_q);
      end
      if (wr_fire) out_rd_q <= ptr_inc(out_rd_q);
      case ({out_push, wr_fire})
        2'b10:   out_cnt_q <= out_cnt_q + 1'b1;
        2'b01:   out_cnt_q <= out_cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Flush sequencing; done fires the cycle after the last write-back leaves
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      occ_q      <= '0;
      idle       <= 1'b1;
      flush_done <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      idle       <= (occ_d == '0);
      flush_done <= 1'b0;
      case (state_q)
        ST_RUN:   if (flush) state_q <= ST_DRAIN;
        ST_DRAIN: if (occ_d == '0) begin
          state_q    <= ST_DONE;
          flush_done <= 1'b1;
        end
        ST_DONE:  state_q <= flush ? ST_WAIT : ST_RUN;
        ST_WAIT:  if (!flush) state_q <= ST_RUN;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_blend_scheduler.sv
// Directed bench for blend_scheduler with a framebuffer responder, a behavioural
// blender and a write-back scoreboard.
module tb_blend_scheduler;

  localparam int unsigned BLAT = 2;
  localparam logic [3:0] F_ZERO      = 4'h0;
  localparam logic [3:0] F_ONE       = 4'h1;
  localparam logic [3:0] F_SRC_ALPHA = 4'h4;
  localparam logic [3:0] F_OMSA      = 4'h5;

  logic        aclk = 1'b0;
  logic        reset;
  logic        conf_enable;
  logic [3:0]  conf_s_factor, conf_d_factor;
  logic        flush, flush_done, idle;
  logic        s_frag_valid, s_frag_ready;
  logic [15:0] s_frag_addr;
  logic [31:0] s_frag_color;
  logic        rd_req_valid, rd_req_ready;
  logic [15:0] rd_req_addr;
  logic        rd_rsp_valid, rd_rsp_ready;
  logic [31:0] rd_rsp_data;
  logic [3:0]  blend_s_factor, blend_d_factor;
  logic [31:0] blend_src_color, blend_dst_color, blend_color;
  logic        m_wr_valid, m_wr_ready;
  logic [15:0] m_wr_addr;
  logic [31:0] m_wr_data;

  blend_scheduler #(.PIXEL_WIDTH(32), .ADDR_WIDTH(16), .BLEND_LATENCY(BLAT), .MAX_INFLIGHT(4)) dut (
    .aclk(aclk), .reset(reset),
    .conf_enable(conf_enable), .conf_s_factor(conf_s_factor), .conf_d_factor(conf_d_factor),
    .flush(flush), .flush_done(flush_done), .idle(idle),
    .s_frag_valid(s_frag_valid), .s_frag_ready(s_frag_ready),
    .s_frag_addr(s_frag_addr), .s_frag_color(s_frag_color),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready), .rd_rsp_data(rd_rsp_data),
    .blend_s_factor(blend_s_factor), .blend_d_factor(blend_d_factor),
    .blend_src_color(blend_src_color), .blend_dst_color(blend_dst_color),
    .blend_color(blend_color),
    .m_wr_valid(m_wr_valid), .m_wr_ready(m_wr_ready),
    .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data)
  );

  always #5 aclk = ~aclk;

  typedef struct packed { logic [15:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [31:0] data; int due; } rsp_t;

  wr_t         expq[$];
  rsp_t        rspq[$];
  logic [31:0] fb [256];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          wr_count = 0;
  int          cyc = 0;
  int          rsp_delay = 3;
  logic        rsp_fire = 1'b0;
  logic [31:0] bl_pipe [BLAT];

  always @(posedge aclk) cyc <= cyc + 1;

  function automatic int fval(input logic [3:0] code, input int sa);
    case (code)
      F_ONE:       return 255;
      F_SRC_ALPHA: return sa;
      F_OMSA:      return 255 - sa;
      default:     return 0;
    endcase
  endfunction

  function automatic logic [31:0] blend_fn(input logic [31:0] src, input logic [31:0] dst,
                                           input logic [3:0] sf, input logic [3:0] df);
    logic [31:0] r;
    int fs, fd, v;
    fs = fval(sf, int'(src[31:24]));
    fd = fval(df, int'(src[31:24]));
    r = '0;
    for (int ch = 0; ch < 4; ch++) begin
      v = (int'(src[8*ch +: 8]) * fs + int'(dst[8*ch +: 8]) * fd) / 255;
      if (v > 255) v = 255;
      r[8*ch +: 8] = 8'(v);
    end
    return r;
  endfunction

  // Behavioural blender: fixed latency, never stalls
  always @(posedge aclk) begin
    bl_pipe[0] <= blend_fn(blend_src_color, blend_dst_color, blend_s_factor, blend_d_factor);
    for (int i = 1; i < int'(BLAT); i++) bl_pipe[i] <= bl_pipe[i-1];
  end
  assign blend_color = bl_pipe[BLAT-1];

  // Framebuffer read port: in-order responses rsp_delay cycles after the request
  always @(negedge aclk) begin
    if (!reset && rd_req_valid && rd_req_ready)
      rspq.push_back('{fb[rd_req_addr[7:0]], cyc + rsp_delay});
    rsp_fire = !reset && rd_rsp_valid && rd_rsp_ready;
  end

  always @(posedge aclk) begin
    #1;
    if (reset) rspq.delete();
    else if (rsp_fire && rspq.size() > 0) void'(rspq.pop_front());
    if (rspq.size() > 0 && rspq[0].due <= cyc) begin
      rd_rsp_valid = 1'b1;
      rd_rsp_data  = rspq[0].data;
    end else begin
      rd_rsp_valid = 1'b0;
      rd_rsp_data  = '0;
    end
  end

  // Write-back monitor
  always @(negedge aclk) begin
    wr_t e;
    if (reset) expq.delete();
    else if (m_wr_valid && m_wr_ready) begin
      wr_count++;
      n_tests++;
      if (expq.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, none expected", m_wr_addr, m_wr_data);
      end else begin
        e = expq.pop_front();
        if (m_wr_addr !== e.addr || m_wr_data !== e.data) begin
          n_fail++;
          $display("FAIL wr_data: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                   m_wr_addr, m_wr_data, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_frag(input logic [15:0] addr, input logic [31:0] color, input logic [31:0] exp);
    logic ok = 1'b0;
    s_frag_valid = 1'b1;
    s_frag_addr  = addr;
    s_frag_color = color;
    for (int k = 0; k < 100; k++) begin
      @(negedge aclk);
      if (s_frag_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("frag_accept", 32'(ok), 32'd1);
    if (ok) expq.push_back('{addr, exp});
    tick();
    s_frag_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge aclk);
      if (idle) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("wait_idle", 32'(ok), 32'd1);
    tick();
  endtask

  task automatic blend_frag(input logic [15:0] addr, input logic [31:0] src,
                            input logic [31:0] dst, input logic [31:0] exp);
    logic seen = 1'b0;
    fb[addr[7:0]] = dst;
    s_frag_valid = 1'b1;
    s_frag_addr  = addr;
    s_frag_color = src;
    @(negedge aclk);
    check("blend_rdreq_valid", 32'(rd_req_valid), 32'd1);
    check("blend_rdreq_addr", 32'(rd_req_addr), 32'(addr));
    check("blend_frag_ready", 32'(s_frag_ready), 32'd1);
    if (s_frag_ready) expq.push_back('{addr, exp});
    tick();
    s_frag_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge aclk);
      if (rd_rsp_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("blend_rsp_seen", 32'(seen), 32'd1);
    check("blend_rsp_ready", 32'(rd_rsp_ready), 32'd1);
    check("blend_src", blend_src_color, src);
    check("blend_dst", blend_dst_color, dst);
    check("blend_sfac", 32'(blend_s_factor), 32'(F_SRC_ALPHA));
    check("blend_dfac", 32'(blend_d_factor), 32'(F_OMSA));
    tick();
    wait_idle();
  endtask

  initial begin
    int   lat, last_wr, pulses, pulse_cyc, wr_before;
    logic ok;
    reset = 1'b1;
    conf_enable = 1'b0;
    conf_s_factor = F_ONE;
    conf_d_factor = F_ZERO;
    flush = 1'b0;
    s_frag_valid = 1'b0;
    s_frag_addr = '0;
    s_frag_color = '0;
    rd_req_ready = 1'b1;
    rd_rsp_valid = 1'b0;
    rd_rsp_data = '0;
    m_wr_ready = 1'b1;
    for (int i = 0; i < 256; i++) fb[i] = '0;

    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_wr_valid", 32'(m_wr_valid), 32'd0);
    check("rst_flush_done", 32'(flush_done), 32'd0);
    check("rst_rsp_ready", 32'(rd_rsp_ready), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Bypass: source echoed, write-back valid four cycles after accept
    s_frag_valid = 1'b1;
    s_frag_addr  = 16'h0010;
    s_frag_color = 32'h11223344;
    @(negedge aclk);
    check("byp_ready", 32'(s_frag_ready), 32'd1);
    check("byp_no_rdreq", 32'(rd_req_valid), 32'd0);
    if (s_frag_ready) expq.push_back('{16'h0010, 32'h11223344});
    tick();
    s_frag_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge aclk);
      if (m_wr_valid) begin
        lat = k;
        break;
      end
      tick();
    end
    check("byp_latency", 32'(lat), 32'd4);
    tick();
    wait_idle();

    // Blend with SRC_ALPHA / ONE_MINUS_SRC_ALPHA
    conf_enable = 1'b1;
    conf_s_factor = F_SRC_ALPHA;
    conf_d_factor = F_OMSA;
    blend_frag(16'h0020, 32'h80FF4020, 32'h00000000, 32'h40802010);
    blend_frag(16'h0021, 32'h80000000, 32'h00FFFFFF, 32'h407F7F7F);

    // Hazard: second fragment to the same pixel waits for the first write-back
    conf_s_factor = F_ONE;
    conf_d_factor = F_ZERO;
    rsp_delay = 1;
    fb[8'h30] = 32'h0;
    m_wr_ready = 1'b0;
    send_frag(16'h0030, 32'h01020304, 32'h01020304);
    s_frag_valid = 1'b1;
    s_frag_addr  = 16'h0030;
    s_frag_color = 32'h05060708;
    ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge aclk);
      if (s_frag_ready || rd_req_valid) ok = 1'b0;
      tick();
    end
    check("haz_blocked", 32'(ok), 32'd1);
    @(negedge aclk);
    check("haz_first_pending", 32'(m_wr_valid), 32'd1);
    tick();
    m_wr_ready = 1'b1;
    @(negedge aclk);
    check("haz_free_same_cycle", 32'(s_frag_ready), 32'd0);
    tick();
    @(negedge aclk);
    check("haz_ready_after_free", 32'(s_frag_ready), 32'd1);
    check("haz_rdreq_after_free", 32'(rd_req_valid), 32'd1);
    if (s_frag_ready) expq.push_back('{16'h0030, 32'h05060708});
    tick();
    s_frag_valid = 1'b0;
    wait_idle();

    // Full: fifth fragment waits for a free slot
    conf_enable = 1'b0;
    m_wr_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send_frag(16'h0040 + 16'(i), 32'hC0DE0000 + 32'(i), 32'hC0DE0000 + 32'(i));
    s_frag_valid = 1'b1;
    s_frag_addr  = 16'h0044;
    s_frag_color = 32'hC0DE0004;
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      if (s_frag_ready) ok = 1'b0;
      tick();
    end
    check("full_blocked", 32'(ok), 32'd1);
    check("full_wr_pending", 32'(m_wr_valid), 32'd1);
    m_wr_ready = 1'b1;
    @(negedge aclk);
    check("full_block_on_free", 32'(s_frag_ready), 32'd0);
    tick();
    m_wr_ready = 1'b0;
    @(negedge aclk);
    check("full_accept_next", 32'(s_frag_ready), 32'd1);
    if (s_frag_ready) expq.push_back('{16'h0044, 32'hC0DE0004});
    tick();
    s_frag_valid = 1'b0;
    m_wr_ready = 1'b1;
    wait_idle();

    // Flush with two fragments in flight
    m_wr_ready = 1'b0;
    send_frag(16'h0050, 32'hAAAA0050, 32'hAAAA0050);
    send_frag(16'h0051, 32'hAAAA0051, 32'hAAAA0051);
    flush = 1'b1;
    tick();
    s_frag_valid = 1'b1;
    s_frag_addr  = 16'h0052;
    s_frag_color = 32'hAAAA0052;
    m_wr_ready = 1'b1;
    ok = 1'b1;
    last_wr = -100;
    pulses = 0;
    pulse_cyc = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge aclk);
      if (s_frag_ready) ok = 1'b0;
      if (m_wr_valid && m_wr_ready) last_wr = cyc;
      if (flush_done) begin
        pulses++;
        pulse_cyc = cyc;
      end
      tick();
    end
    check("flush_no_accept", 32'(ok), 32'd1);
    check("flush_done_pulses", 32'(pulses), 32'd1);
    check("flush_done_timing", 32'(pulse_cyc), 32'(last_wr + 1));
    @(negedge aclk);
    check("flush_idle", 32'(idle), 32'd1);
    tick();
    s_frag_valid = 1'b0;
    flush = 1'b0;
    repeat (2) tick();

    // Async reset with three fragments in flight
    m_wr_ready = 1'b0;
    send_frag(16'h0060, 32'h60606060, 32'h60606060);
    send_frag(16'h0061, 32'h61616161, 32'h61616161);
    send_frag(16'h0062, 32'h62626262, 32'h62626262);
    repeat (3) tick();
    @(negedge aclk);
    check("prerst_wr_valid", 32'(m_wr_valid), 32'd1);
    check("prerst_idle", 32'(idle), 32'd0);
    tick();
    reset = 1'b1;
    #1;
    check("arst_wr_valid", 32'(m_wr_valid), 32'd0);
    check("arst_idle", 32'(idle), 32'd1);
    check("arst_rsp_ready", 32'(rd_rsp_ready), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    m_wr_ready = 1'b1;
    wr_before = wr_count;
    repeat (20) tick();
    check("rst_no_write", 32'(wr_count), 32'(wr_before));
    send_frag(16'h0070, 32'hA5A5A5A5, 32'hA5A5A5A5);
    wait_idle();
    check("sb_drained", 32'(expq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
